cla_adder_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 32-bit combinational CLA.

---
 rtl/cla_pkg.sv | 28 ++
 rtl/cla_adder_pipe_group.sv | 40 ++++
 rtl/cla_adder_pipe.sv | 178 +++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined carry-lookahead adder.
// The stage payload is sized by CLA_WIDTH; change it here to build a wider adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH  = 32;
  localparam int unsigned CLA_BLOCK  = 4;
  localparam int unsigned CLA_STAGES = 2;
  localparam int unsigned NGROUPS    = CLA_WIDTH / CLA_BLOCK;
  localparam int unsigned GPS        = NGROUPS / CLA_STAGES;

  // One pipeline beat: operands (D already inverted for subtract), partial sum and carry.
  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] a_rem;
    logic [CLA_WIDTH-1:0] d_rem;
    logic [CLA_WIDTH-1:0] s_done;
    logic                 carry;
    logic                 sub;
    logic                 unsign;
  } cla_stage_t;

  // Legal geometry: whole groups, whole groups per stage, payload matches the struct.
  function automatic bit cla_cfg_ok(int unsigned w, int unsigned b, int unsigned s);
    if (b == 0 || s == 0) return 1'b0;
    return (w == CLA_WIDTH) && (w % b == 0) && (s <= w / b) && ((w / b) % s == 0);
  endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// BLOCK-bit carry-lookahead group: sum for a given carry-in plus group generate/propagate.
// Generate/propagate never depend on cin so the enclosing lookahead chain stays acyclic.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] d,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] c;

  assign gen  = a & d;
  assign prop = a ^ d;
  assign p    = &prop;

  always_comb begin
    g = 1'b0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      g = gen[i] | (prop[i] & g);
    end
  end

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 1; i < BLOCK; i++) begin
      c[i] = gen[i-1] | (prop[i-1] & c[i-1]);
    end
    sum = prop ^ c;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_SAT_EN to clamp S on overflow instead of wrapping modulo 2^WIDTH.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_WIDTH,
  parameter int unsigned BLOCK  = CLA_BLOCK,
  parameter int unsigned STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] D,
  input  logic             Cnt,
  input  logic             unsign,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             sign
);

  localparam int unsigned N_GRP     = WIDTH / BLOCK;
  localparam int unsigned G_PER_STG = N_GRP / STAGES;
  localparam int unsigned STG_BITS  = G_PER_STG * BLOCK;

  if (!cla_cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
    $error("cla_adder_pipe: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             sign_q, sign_d;

  logic             fin_valid;
  logic [WIDTH-1:0] fin_s;
  logic             fin_cout;
  logic             fin_sign;

  // Single global enable: the whole pipe moves unless a result is stuck at the output.
  logic adv;
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * STG_BITS;

    cla_stage_t           st_in;
    logic [STG_BITS-1:0]  grp_sum;
    logic [G_PER_STG-1:0] grp_g;
    logic [G_PER_STG-1:0] grp_p;
    logic [G_PER_STG:0]   grp_c;
    logic [WIDTH-1:0]     s_new;

    if (k == 0) begin : g_entry
      // Subtract is folded in here: A + ~D + ~borrow.
      always_comb begin
        st_in        = '0;
        st_in.valid  = in_valid;
        st_in.a_rem  = A;
        st_in.d_rem  = sub ? ~D : D;
        st_in.carry  = Cnt ^ sub;
        st_in.sub    = sub;
        st_in.unsign = unsign;
      end
    end else begin : g_link
      assign st_in = g_stage[k-1].g_reg.pipe_q;
    end

    for (genvar j = 0; j < G_PER_STG; j++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a   (st_in.a_rem[LO + j*BLOCK +: BLOCK]),
        .d   (st_in.d_rem[LO + j*BLOCK +: BLOCK]),
        .cin (grp_c[j]),
        .sum (grp_sum[j*BLOCK +: BLOCK]),
        .g   (grp_g[j]),
        .p   (grp_p[j])
      );
    end

    // Group-level lookahead across this stage's slice.
    always_comb begin
      grp_c    = '0;
      grp_c[0] = st_in.carry;
      for (int unsigned j = 0; j < G_PER_STG; j++) begin
        grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
    end

    // Bits above the current slice are still zero, so OR merges the new sum bits.
    assign s_new = st_in.s_done | (WIDTH'(grp_sum) << LO);

    if (k < STAGES - 1) begin : g_reg
      cla_stage_t pipe_d;
      cla_stage_t pipe_q;

      always_comb begin
        pipe_d = pipe_q;
        if (adv) begin
          pipe_d        = st_in;
          pipe_d.s_done = s_new;
          pipe_d.carry  = grp_c[G_PER_STG];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end
    end else begin : g_last
      logic cmsb;

      always_comb begin
        cmsb      = st_in.a_rem[WIDTH-1] ^ st_in.d_rem[WIDTH-1] ^ s_new[WIDTH-1];
        fin_valid = st_in.valid;
        fin_cout  = grp_c[G_PER_STG];
        fin_sign  = st_in.unsign ? (fin_cout ^ st_in.sub) : (cmsb ^ fin_cout);
        fin_s     = s_new;
`ifdef CLA_SAT_EN
        // Signed overflow only happens with equal operand signs; A's MSB picks the rail.
        if (fin_sign) begin
          if (st_in.unsign) begin
            fin_s = st_in.sub ? '0 : '1;
          end else begin
            fin_s = {st_in.a_rem[WIDTH-1], {(WIDTH-1){~st_in.a_rem[WIDTH-1]}}};
          end
        end
`endif
      end

      if (k > 0) begin : g_dead
        // Lower operand bits were consumed by earlier stages.
        logic unused_consumed;
        assign unused_consumed = ^{st_in.a_rem[LO-1:0], st_in.d_rem[LO-1:0]};
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    sign_d      = sign_q;
    if (adv) begin
      out_valid_d = fin_valid;
      s_d         = fin_s;
      cout_d      = fin_cout;
      sign_d      = fin_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      sign_q      <= sign_d;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: integer reference model, queued expectations,
// independent output monitor, directed vectors, stall stream, mid-flight reset and random traffic.
module tb_cla_adder_pipe;

  localparam int unsigned W   = 32;
  parameter  int unsigned STG = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] D;
  logic         Cnt;
  logic         unsign;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         sign;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   drained    = 0;
  int   stall_seen = 0;
  logic acc;

  cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(STG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .D         (D),
    .Cnt       (Cnt),
    .unsign    (unsign),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer result, range test for overflow, modulo for wrap.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] d, logic cnt, logic uns, logic sb);
    exp_t   e;
    longint ru, r, lo, hi;
    ru = sb ? longint'(a) - longint'(d) - longint'(cnt)
            : longint'(a) + longint'(d) + longint'(cnt);
    if (uns) begin
      r  = ru;
      lo = 0;
      hi = (longint'(1) << W) - 1;
    end else begin
      r  = sb ? longint'($signed(a)) - longint'($signed(d)) - longint'(cnt)
              : longint'($signed(a)) + longint'($signed(d)) + longint'(cnt);
      lo = -(longint'(1) << (W-1));
      hi = (longint'(1) << (W-1)) - 1;
    end
    e.a  = a;
    e.d  = d;
    e.co = sb ? (ru >= 0) : (ru > (longint'(1) << W) - 1);
    e.sg = (r < lo) || (r > hi);
    e.s  = W'(ru);
`ifdef CLA_SAT_EN
    if (e.sg) begin
      if (uns) e.s = sb ? '0 : '1;
      else     e.s = (r > hi) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    end
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive at posedge+1, note acceptance at negedge, return at next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] d,
                      input logic cnt, input logic uns, input logic sb,
                      input logic ordy, output logic accepted);
    in_valid  = v;
    A         = a;
    D         = d;
    Cnt       = cnt;
    unsign    = uns;
    sub       = sb;
    out_ready = ordy;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) q.push_back(model(a, d, cnt, uns, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a0;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a0);
  endtask

  // Single beat into an empty pipe; measures edges from accept to out_valid.
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic cnt, input logic uns, input logic sb);
    logic a0;
    int   n;
    step(1'b1, a, d, cnt, uns, sb, 1'b1, a0);
    checks++;
    if (!a0) begin
      failures++;
      $display("FAIL directed_accept in_valid&in_ready=%b want 1", a0);
    end
    n = 1;
    while (!out_valid && n < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a0);
      n++;
    end
    checks++;
    if (n != int'(STG)) begin
      failures++;
      $display("FAIL latency got %0d edges want %0d", n, STG);
    end
    idle(1);
  endtask

  // Monitor: a beat is consumed at the edge after a negedge showing out_valid & out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !out_ready) begin
        stall_seen++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_stall in_ready=%b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat S=%h Cout=%b sign=%b with empty scoreboard", S, Cout, sign);
        end else begin
          e = q.pop_front();
          drained++;
          if (S !== e.s || Cout !== e.co || sign !== e.sg) begin
            failures++;
            $display("FAIL result a=%h d=%h got S=%h Cout=%b sign=%b want S=%h Cout=%b sign=%b",
                     e.a, e.d, S, Cout, sign, e.s, e.co, e.sg);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int c;
    int d0;
    int st0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    D         = '0;
    Cnt       = 1'b0;
    unsign    = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (S !== '0 || Cout !== 1'b0 || sign !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs S=%h Cout=%b sign=%b want 0/0/0", S, Cout, sign);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end

    directed(32'h0077_8866, 32'h0055_4433, 1'b0, 1'b1, 1'b0);
    directed(32'h0077_8866, 32'h0055_4433, 1'b1, 1'b1, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    directed(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
    directed(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 1'b1);
    directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    directed(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b1);

    // Eight beats (i, i) with the sink stalled for cycles 3..6.
    d0  = drained;
    st0 = stall_seen;
    i   = 0;
    for (c = 0; c < 60 && (i < 8 || q.size() != 0); c++) begin
      step(i < 8, W'(i), W'(i), 1'b0, 1'b1, 1'b0, !(c >= 3 && c <= 6), acc);
      if (acc) i++;
    end
    checks++;
    if (i != 8 || drained - d0 != 8) begin
      failures++;
      $display("FAIL stream_count accepted=%0d drained=%0d want 8/8", i, drained - d0);
    end
    checks++;
    if (stall_seen == st0) begin
      failures++;
      $display("FAIL stream_stall stalled_cycles=%0d want >0", stall_seen - st0);
    end

    // Two beats in flight, then a one-cycle reset: nothing may emerge afterwards.
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 32'h0BAD_F00D, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    rst = 1'b0;
    q.delete();
    checks++;
    if (out_valid !== 1'b0 || S !== '0) begin
      failures++;
      $display("FAIL midreset_outputs out_valid=%b S=%h want 0/0", out_valid, S);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    d0 = drained;
    idle(int'(STG) + 6);
    checks++;
    if (drained != d0) begin
      failures++;
      $display("FAIL midreset_stale beats=%0d want 0", drained - d0);
    end

    // Random traffic with random bubbles and back-pressure.
    for (int n = 0; n < 500; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rd;
      ra = pick();
      rd = pick();
      step($urandom_range(0, 9) < 7, ra, rd, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, acc);
    end
    for (int n = 0; n < 100 && q.size() != 0; n++) idle(1);
    idle(2);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
